// File: rtl/square_rom_arbiter.sv
// Round-robin arbiter sharing one square ROM lookup among NREQ requesters.
// Each grant latches the winner's operand, looks it up for one cycle and
// returns the tagged square over a valid/ready response channel.
module square_rom_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_n,
  input  logic [NREQ-1:0]     req_sign,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [3:0]          rsp_n,
  output logic                rsp_sign,
  output logic [7:0]          rsp_square,
  output logic                busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            grant_found;
  logic [ID_W-1:0] win_id;
  logic [3:0]      win_n;
  logic            win_sign;
  logic [7:0]      rom_data;
  logic [3:0]      req_mag [NREQ];
  int unsigned     cand;

  // Unpack the magnitude bus into one nibble per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_mag[g] = req_n[4*g+3:4*g];
  end

  // Square lookup table driven by the latched operand.
  function automatic logic [7:0] square_rom(input logic [3:0] n);
    return 8'(n) * 8'(n);
  endfunction

  assign rom_data = square_rom(win_n);

  // First valid requester at or above the pointer, wrapping at NREQ-1.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        winner      = ID_W'(cand);
      end
    end
  end

  // Accept strobe is combinational and suppressed while reset is held.
  assign req_ready = (rst_n && (state == IDLE) && grant_found)
                     ? (NREQ'(1) << winner) : '0;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_id     <= '0;
      win_n      <= '0;
      win_sign   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_n      <= '0;
      rsp_sign   <= 1'b0;
      rsp_square <= '0;
      ptr        <= '0;
    end else begin
      if (state == IDLE && grant_found) begin
        win_id   <= winner;
        win_n    <= req_mag[IDX_W'(winner)];
        win_sign <= req_sign[IDX_W'(winner)];
      end
      if (state == LOOKUP) begin
        rsp_square <= rom_data;
        rsp_id     <= win_id;
        rsp_n      <= win_n;
        rsp_sign   <= win_sign;
        rsp_valid  <= 1'b1;
      end
      if (state == RESP && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        ptr       <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_square_rom_arbiter.sv
// Directed bench for square_rom_arbiter: vector table plus hand sequences.
module tb_square_rom_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [15:0]     req_n;
  logic [3:0]      req_sign;
  logic [3:0]      req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [3:0]      rsp_n;
  logic            rsp_sign;
  logic [7:0]      rsp_square;
  logic            busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] n;
    logic [3:0]  sign;
    logic [1:0]  id;
    logic [7:0]  sq;
    logic        sgn;
  } vec_t;

  vec_t vecs [9];

  square_rom_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_n      (req_n),
    .req_sign   (req_sign),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_n      (rsp_n),
    .rsp_sign   (rsp_sign),
    .rsp_square (rsp_square),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction with rsp_ready high; entered and left at posedge+1 in IDLE.
  task automatic run_txn(input vec_t v);
    logic [15:0] sh;
    bit got;
    req_valid = v.valid;
    req_n     = v.n;
    req_sign  = v.sign;
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no req_ready within 20 cycles, expected id %0d", v.id);
      @(posedge clk); #1;
      return;
    end
    chk("grant_onehot", 32'(req_ready), 32'(4'b0001 << v.id));
    @(posedge clk); #1;
    chk("lookup_ready", 32'(req_ready), 32'd0);
    chk("lookup_busy", 32'(busy), 32'd1);
    chk("lookup_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    sh = v.n >> (4 * v.id);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_square", 32'(rsp_square), 32'(v.sq));
    chk("rsp_sign", 32'(rsp_sign), 32'(v.sgn));
    chk("rsp_n", 32'(rsp_n), 32'(sh[3:0]));
    chk("resp_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    // Round-robin with all four valid, n = 5,9,1,8 signs 0,1,0,1.
    vecs[0] = '{4'hF, 16'h8195, 4'b1010, 2'd0, 8'd25,  1'b0};
    vecs[1] = '{4'hF, 16'h8195, 4'b1010, 2'd1, 8'd81,  1'b1};
    vecs[2] = '{4'hF, 16'h8195, 4'b1010, 2'd2, 8'd1,   1'b0};
    vecs[3] = '{4'hF, 16'h8195, 4'b1010, 2'd3, 8'd64,  1'b1};
    vecs[4] = '{4'hF, 16'h8195, 4'b1010, 2'd0, 8'd25,  1'b0};
    // Single request on requester 2, n=15.
    vecs[5] = '{4'b0100, 16'h0F00, 4'b0000, 2'd2, 8'd225, 1'b0};
    // Pointer now 3: requesters 0 (n=7) and 3 (n=13, sign) -> 3 then 0.
    vecs[6] = '{4'b1001, 16'hD007, 4'b1000, 2'd3, 8'd169, 1'b1};
    vecs[7] = '{4'b1001, 16'hD007, 4'b1000, 2'd0, 8'd49,  1'b0};
    // Negative zero on requester 1.
    vecs[8] = '{4'b0010, 16'h0000, 4'b0010, 2'd1, 8'd0,   1'b1};

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_n     = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    chk("reset_n", 32'(rsp_n), 32'd0);
    chk("reset_sign", 32'(rsp_sign), 32'd0);
    chk("reset_square", 32'(rsp_square), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Backpressure: requester 2, n=12, sign=1, rsp_ready low for 5 cycles.
    req_valid = 4'b0100;
    req_n     = 16'h0C00;
    req_sign  = 4'b0100;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_square", 32'(rsp_square), 32'd144);
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_sign", 32'(rsp_sign), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_busy", 32'(busy), 32'd0);

    // Sweep every magnitude on requester 1.
    for (int n = 0; n < 16; n++) begin
      sv.valid = 4'b0010;
      sv.n     = 16'(n) << 4;
      sv.sign  = 4'b0000;
      sv.id    = 2'd1;
      sv.sq    = 8'(n * n);
      sv.sgn   = 1'b0;
      run_txn(sv);
    end

    // Reset during LOOKUP.
    req_valid = 4'b1000;
    req_n     = 16'h3000;
    req_sign  = 4'b0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst1_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    chk("rst1_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst1_valid", 32'(rsp_valid), 32'd0);
    chk("rst1_busy", 32'(busy), 32'd0);
    chk("rst1_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Reset during RESP.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst2_valid_pre", 32'(rsp_valid), 32'd1);
    chk("rst2_id_pre", 32'(rsp_id), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", 32'(rsp_valid), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'd0);
    chk("rst2_id", 32'(rsp_id), 32'd0);
    chk("rst2_square", 32'(rsp_square), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh request after reset: pointer back at 0, so requester 0 wins over 3.
    sv = '{4'b1001, 16'hA006, 4'b0000, 2'd0, 8'd36, 1'b0};
    run_txn(sv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
